// File: rtl/trap_monitor.sv
// trap_monitor: watches a multi-channel commit stream for the program's exit trap.
// It counts retired instructions and elapsed cycles, keeps a ring of recent PCs,
// declares a hang after TIMEOUT idle cycles, and settles in an absorbing DONE state.
// Optional feature macro: TRAP_MONITOR_REPORT_EN prints a run summary on DONE entry
// and ends the simulation; without it the block contains no simulation tasks.
module trap_monitor #(
  parameter int NCOMMIT     = 2,
  parameter int XLEN        = 64,
  parameter int TRACE_DEPTH = 8,
  parameter int TIMEOUT     = 4096,
  parameter int DRAIN       = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NCOMMIT-1:0]            commit_valid,
  input  logic [NCOMMIT*XLEN-1:0]       commit_pc,
  input  logic [NCOMMIT*32-1:0]         commit_inst,
  input  logic [NCOMMIT-1:0]            exit,
  input  logic [XLEN-1:0]               a0,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [XLEN-1:0]               trace_pc,
  output logic [1:0]                    state,
  output logic                          done,
  output logic                          good,
  output logic                          hang,
  output logic [XLEN-1:0]               exit_pc,
  output logic [31:0]                   exit_inst,
  output logic [XLEN-1:0]               exit_code,
  output logic [63:0]                   instr_cnt,
  output logic [63:0]                   cycle_cnt
);

  localparam int IDX_W   = $clog2(TRACE_DEPTH);
  localparam int CH_W    = (NCOMMIT > 1) ? $clog2(NCOMMIT) : 1;
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN + 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN - 1);

  // Encoding 3 is never entered; the next-state logic treats it as DONE.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [63:0]         instr_q, instr_d;
  logic [63:0]         cycle_q, cycle_d;
  logic                done_q, done_d;
  logic                good_q, good_d;
  logic                hang_q, hang_d;
  logic [XLEN-1:0]     exit_pc_q, exit_pc_d;
  logic [31:0]         exit_inst_q, exit_inst_d;
  logic [XLEN-1:0]     exit_code_q, exit_code_d;

  logic [XLEN-1:0]     hist_q [TRACE_DEPTH];
  logic [IDX_W-1:0]    wp_q, wp_d;
  logic [IDX_W-1:0]    wr_idx [NCOMMIT];
  logic [IDX_W-1:0]    ofs;
  logic [IDX_W-1:0]    rd_idx;

  logic [NCOMMIT-1:0]  acc;
  logic                trap_hit;
  logic [CH_W-1:0]     trap_ch;
  logic [2:0]          acc_cnt;
  logic                commit_any;

  function automatic logic [2:0] popcount(input logic [NCOMMIT-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NCOMMIT; i++) n = n + 3'(v[i]);
    return n;
  endfunction

  // Accepted channels: valid ones up to and including the lowest trapping channel, RUN only.
  always_comb begin
    acc      = '0;
    trap_hit = 1'b0;
    trap_ch  = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      if (!trap_hit) begin
        acc[i] = commit_valid[i];
        if (commit_valid[i] && exit[i]) begin
          trap_hit = 1'b1;
          trap_ch  = CH_W'(i);
        end
      end
    end
    if (state_q != ST_RUN) begin
      acc      = '0;
      trap_hit = 1'b0;
    end
    acc_cnt    = popcount(acc);
    commit_any = |acc;
  end

  // Ring write slots: accepted commits pack contiguously from wp in channel order.
  always_comb begin
    ofs = '0;
    for (int i = 0; i < NCOMMIT; i++) begin
      wr_idx[i] = wp_q + ofs;
      ofs       = ofs + IDX_W'(acc[i]);
    end
    wp_d   = wp_q + IDX_W'(acc_cnt);
    rd_idx = wp_q - IDX_W'(1) - trace_idx;
  end

  // FSM next state together with counters, captured trap fields and status flags.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    idle_d      = idle_q;
    instr_d     = instr_q;
    cycle_d     = cycle_q;
    done_d      = done_q;
    good_d      = good_q;
    hang_d      = hang_q;
    exit_pc_d   = exit_pc_q;
    exit_inst_d = exit_inst_q;
    exit_code_d = exit_code_q;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + 64'd1;
        instr_d = instr_q + 64'(acc_cnt);
        if (trap_hit) begin
          state_d     = ST_DRAIN;
          drain_d     = '0;
          exit_pc_d   = commit_pc[trap_ch*XLEN +: XLEN];
          exit_inst_d = commit_inst[trap_ch*32 +: 32];
          exit_code_d = a0;
        end else if (commit_any) begin
          idle_d = '0;
        end else if (idle_q == IDLE_MAX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          hang_d  = 1'b1;
          good_d  = 1'b0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_DRAIN: begin
        cycle_d = cycle_q + 64'd1;
        if (drain_q == DRAIN_MAX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          hang_d  = 1'b0;
          good_d  = (exit_code_q == '0);
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    endcase
  end

  // Control and status registers; reset aborts any run in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      idle_q      <= '0;
      instr_q     <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      hang_q      <= 1'b0;
      exit_pc_q   <= '0;
      exit_inst_q <= '0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      idle_q      <= idle_d;
      instr_q     <= instr_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
      good_q      <= good_d;
      hang_q      <= hang_d;
      exit_pc_q   <= exit_pc_d;
      exit_inst_q <= exit_inst_d;
      exit_code_q <= exit_code_d;
    end
  end

  // PC history ring; a later channel landing on the same slot overwrites an earlier one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < TRACE_DEPTH; k++) hist_q[k] <= '0;
      wp_q <= '0;
    end else begin
      for (int i = 0; i < NCOMMIT; i++) begin
        if (acc[i]) hist_q[wr_idx[i]] <= commit_pc[i*XLEN +: XLEN];
      end
      wp_q <= wp_d;
    end
  end

  assign trace_pc  = hist_q[rd_idx];
  assign state     = state_q;
  assign done      = done_q;
  assign good      = good_q;
  assign hang      = hang_q;
  assign exit_pc   = exit_pc_q;
  assign exit_inst = exit_inst_q;
  assign exit_code = exit_code_q;
  assign instr_cnt = instr_q;
  assign cycle_cnt = cycle_q;

`ifdef TRAP_MONITOR_REPORT_EN
  logic reported_q;

  // One-shot run report once DONE is reached, then end the simulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reported_q <= 1'b0;
    end else if (done_q && !reported_q) begin
      reported_q <= 1'b1;
      $display("trap_monitor: result=%s exit_pc=%h exit_inst=%h exit_code=%h instr_cnt=%0d cycle_cnt=%0d",
               hang_q ? "hang" : (good_q ? "good" : "bad"),
               exit_pc_q, exit_inst_q, exit_code_q, instr_q, cycle_q);
      for (int k = 0; k < TRACE_DEPTH; k++) begin
        $display("trap_monitor: trace[%0d] pc=%h", k, hist_q[wp_q - IDX_W'(k + 1)]);
      end
      $finish;
    end
  end
`else
  // Report disabled: the block is purely synthesizable logic.
`endif

endmodule

// File: tb/tb_trap_monitor.sv
// Self-checking bench for trap_monitor: directed scenarios plus randomized runs,
// all compared every cycle against a transaction-level reference model.
module tb_trap_monitor;
  localparam int NC = 2;
  localparam int XL = 64;
  localparam int TD = 8;
  localparam int TO = 16;
  localparam int DR = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NC-1:0]     commit_valid = '0;
  logic [NC*XL-1:0]  commit_pc = '0;
  logic [NC*32-1:0]  commit_inst = '0;
  logic [NC-1:0]     exit_v = '0;
  logic [XL-1:0]     a0 = '0;
  logic [2:0]        trace_idx = '0;
  logic [XL-1:0]     trace_pc;
  logic [1:0]        state;
  logic              done, good, hang;
  logic [XL-1:0]     exit_pc, exit_code;
  logic [31:0]       exit_inst;
  logic [63:0]       instr_cnt, cycle_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: run phase, committed-PC log, counters and captured trap.
  int          m_phase;
  int          m_drain_left;
  int          m_empty;
  logic [63:0] m_instr, m_cycle, m_epc, m_ecode;
  logic [31:0] m_einst;
  bit          m_good, m_hang;
  logic [63:0] m_hist [$];

  trap_monitor #(.NCOMMIT(NC), .XLEN(XL), .TRACE_DEPTH(TD), .TIMEOUT(TO), .DRAIN(DR)) dut (
    .clock(clock), .reset_n(reset_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .exit(exit_v), .a0(a0), .trace_idx(trace_idx),
    .trace_pc(trace_pc), .state(state), .done(done), .good(good), .hang(hang),
    .exit_pc(exit_pc), .exit_inst(exit_inst), .exit_code(exit_code),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_drain_left = 0; m_empty = 0;
    m_instr = '0; m_cycle = '0; m_epc = '0; m_ecode = '0; m_einst = '0;
    m_good = 0; m_hang = 0;
    m_hist.delete();
  endtask

  function automatic logic [63:0] m_trace(input int idx);
    if (idx < m_hist.size()) return m_hist[m_hist.size() - 1 - idx];
    return 64'd0;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic m_step();
    bit committed, trapped;
    committed = 0; trapped = 0;
    if (m_phase == 0) begin
      for (int i = 0; i < NC; i++) begin
        if (!trapped && commit_valid[i]) begin
          m_hist.push_back(commit_pc[i*XL +: XL]);
          m_instr = m_instr + 64'd1;
          committed = 1;
          if (exit_v[i]) begin
            trapped = 1;
            m_epc   = commit_pc[i*XL +: XL];
            m_einst = commit_inst[i*32 +: 32];
            m_ecode = a0;
          end
        end
      end
      m_cycle = m_cycle + 64'd1;
      if (trapped) begin
        m_phase = 1; m_drain_left = DR;
      end else if (committed) begin
        m_empty = 0;
      end else begin
        m_empty++;
        if (m_empty == TO) begin m_phase = 2; m_hang = 1; m_good = 0; end
      end
    end else if (m_phase == 1) begin
      m_cycle = m_cycle + 64'd1;
      m_drain_left--;
      if (m_drain_left == 0) begin m_phase = 2; m_good = (m_ecode == 64'd0); end
    end
    while (m_hist.size() > 64) void'(m_hist.pop_front());
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".state"},     64'(state),     64'(m_phase));
    chk({tag, ".done"},      64'(done),      64'(m_phase == 2));
    chk({tag, ".good"},      64'(good),      64'(m_phase == 2 && m_good));
    chk({tag, ".hang"},      64'(hang),      64'(m_phase == 2 && m_hang));
    chk({tag, ".instr_cnt"}, instr_cnt,      m_instr);
    chk({tag, ".cycle_cnt"}, cycle_cnt,      m_cycle);
    chk({tag, ".exit_pc"},   exit_pc,        m_epc);
    chk({tag, ".exit_inst"}, 64'(exit_inst), 64'(m_einst));
    chk({tag, ".exit_code"}, exit_code,      m_ecode);
    chk({tag, ".trace_pc"},  trace_pc,       m_trace(int'(trace_idx)));
  endtask

  // One clock: drive at the falling edge, let the rising edge act, sample at the next fall.
  task automatic step(input logic [1:0] v, input logic [1:0] ex,
                      input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] a0v);
    commit_valid = v;
    exit_v       = ex;
    commit_pc    = {p1, p0};
    commit_inst  = {$urandom, $urandom};
    a0           = a0v;
    trace_idx    = 3'($urandom_range(0, 7));
    m_step();
    @(posedge clock);
    @(negedge clock);
    compare_all("cyc");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    commit_valid = '0; exit_v = '0;
    m_reset();
    #1;
    compare_all("rst");
    @(negedge clock);
    compare_all("rst_hold");
    reset_n = 1'b1;
  endtask

  task automatic rand_run(input int maxc);
    int burst, tail;
    logic [1:0] v, ex;
    logic [63:0] a0v;
    burst = 0; tail = 0;
    for (int c = 0; c < maxc; c++) begin
      if (burst > 0) begin
        v = 2'b00; burst--;
      end else begin
        v = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) burst = $urandom_range(4, 20);
      end
      ex = 2'b00;
      if ($urandom_range(0, 29) == 0) ex[0] = 1'b1;
      if ($urandom_range(0, 29) == 0) ex[1] = 1'b1;
      a0v = ($urandom_range(0, 1) == 1) ? 64'd0 : 64'($urandom_range(1, 9));
      step(v, ex, {$urandom, $urandom}, {$urandom, $urandom}, a0v);
      if (m_phase == 2) begin
        tail++;
        if (tail > 3) break;
      end
    end
  endtask

  initial begin
    m_reset();
    @(negedge clock);
    do_reset();

    // Hang: no commits at all -> DONE with hang after the 16th cycle.
    for (int k = 0; k < 15; k++) step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    chk("t048_still_run", 64'(state), 64'd0);
    step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    chk("t048_done", 64'(state), 64'd2);
    chk("t048_hang", 64'(hang), 64'd1);
    chk("t048_cycles", cycle_cnt, 64'd16);
    step(2'b11, 2'b01, 64'h10, 64'h14, 64'd0);
    chk("t048_absorb", 64'(state), 64'd2);

    // A commit in the cycle the timeout would fire wins.
    do_reset();
    for (int k = 0; k < 15; k++) step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    step(2'b01, 2'b00, 64'h40, 64'd0, 64'd0);
    chk("t048_commit_wins", 64'(state), 64'd0);
    for (int k = 0; k < 15; k++) step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    chk("t048_rearm_run", 64'(state), 64'd0);
    step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    chk("t048_rearm_hang", 64'(hang), 64'd1);

    // History ring with 11 single commits.
    do_reset();
    for (int k = 0; k < 11; k++) step(2'b01, 2'b00, 64'h8000_0000 + 64'(4 * k), 64'd0, 64'd0);
    trace_idx = 3'd0; #1;
    chk("t049_trace0", trace_pc, 64'h8000_0028);
    trace_idx = 3'd7; #1;
    chk("t049_trace7", trace_pc, 64'h8000_000C);

    // Dual commits then exit on ch0 with ch1 valid.
    do_reset();
    for (int k = 0; k < 10; k++) step(2'b11, 2'b00, 64'h1000 + 64'(8 * k), 64'h1004 + 64'(8 * k), 64'd0);
    step(2'b11, 2'b01, 64'h2000, 64'h2004, 64'd0);
    trace_idx = 3'd0; #1;
    chk("t047_trace0", trace_pc, 64'h2000);
    chk("t045_instr", instr_cnt, 64'd21);
    chk("t045_drain", 64'(state), 64'd1);
    for (int k = 0; k < 3; k++) step(2'b11, 2'b00, 64'h3000, 64'h3004, 64'd0);
    chk("t045_drain3", 64'(state), 64'd1);
    step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    chk("t045_done", 64'(state), 64'd2);
    chk("t045_good", 64'(good), 64'd1);
    chk("t045_instr_frozen", instr_cnt, 64'd21);

    // Exit on ch1 with nonzero code, ch0 valid too.
    do_reset();
    step(2'b11, 2'b00, 64'h500, 64'h504, 64'd0);
    step(2'b11, 2'b10, 64'h508, 64'h50C, 64'h5);
    chk("t046_code", exit_code, 64'h5);
    chk("t046_instr", instr_cnt, 64'd4);
    chk("t046_pc", exit_pc, 64'h50C);
    for (int k = 0; k < 4; k++) step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    chk("t046_done", 64'(done), 64'd1);
    chk("t046_bad", 64'(good), 64'd0);
    chk("t046_nohang", 64'(hang), 64'd0);

    // Asynchronous reset in the middle of DRAIN, then a fresh run.
    do_reset();
    for (int k = 0; k < 3; k++) step(2'b01, 2'b00, 64'h700 + 64'(4 * k), 64'd0, 64'd0);
    step(2'b01, 2'b01, 64'h710, 64'd0, 64'd0);
    step(2'b00, 2'b00, 64'd0, 64'd0, 64'd0);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("t050_state", 64'(state), 64'd0);
    chk("t050_instr", instr_cnt, 64'd0);
    chk("t050_exit_pc", exit_pc, 64'd0);
    @(negedge clock);
    compare_all("t050_hold");
    reset_n = 1'b1;
    rand_run(300);
    chk("t050_fresh_done", 64'(state), 64'(m_phase));

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      rand_run(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
